// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multi-port register file.
package rf_pkg;

  localparam int RF_XLEN_DEF = 32;
  localparam int RF_NREG_DEF = 32;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read mux with optional write-to-read forwarding.
module rf_read_port #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic [XLEN-1:0] regs [NREG],
  input  logic [AW-1:0]   raddr,
  input  logic            fwd_en,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic hit;

  // Register 0 is never forwarded so it always reads as zero.
  assign hit   = (BYPASS != 0) && fwd_en && (waddr == raddr) && (waddr != '0);
  assign rdata = hit ? wdata : regs[raddr];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending-write scoreboard and sequential full-file clear.
// state    | meaning
// RF_IDLE  | normal operation: writes, reservations and clear requests accepted
// RF_CLEAR | walking cnt from 1 to NREG-1, zeroing one register per cycle
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN_DEF,
  parameter int NREG   = RF_NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  output logic                wr_ready,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREG-1:0]     busy,
  input  logic                clr_req,
  output logic                clr_busy
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wen, clr_sel, rsv_set;
  logic            accept;

  assign clr_busy = (state_q == RF_CLEAR);
  assign wr_ready = ~clr_busy;
  assign accept   = we & wr_ready;
  assign busy     = busy_q;

  // One-hot decodes; bit 0 is masked so register 0 can never be enabled.
  assign wen     = accept ? ((NREG'(1) << waddr) & ~NREG'(1)) : '0;
  assign clr_sel = clr_busy ? (NREG'(1) << cnt_q) : '0;
  assign rsv_set = (rsv_valid && !clr_busy) ? ((NREG'(1) << rsv_addr) & ~NREG'(1)) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      RF_CLEAR: begin
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reservation is applied last so it wins over a same-register write.
  always_comb begin
    busy_d    = (busy_q & ~clr_sel & ~wen) | rsv_set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      regs[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (clr_sel[i]) regs[i] <= '0;
        else if (wen[i]) regs[i] <= wdata;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .BYPASS(BYPASS)
    ) u_rd (
      .regs  (regs),
      .raddr (raddr[k*AW +: AW]),
      .fwd_en(accept),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized self-checking bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        wr_ready;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic [31:0] busy;
  logic        clr_req = 1'b0;
  logic        clr_busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  bit          clearing;
  int          pos;

  reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ready(wr_ready), .raddr(raddr), .rdata(rdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mbusy = '0;
    clearing = 0;
    pos = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!clearing && we && waddr == a && waddr != 0) return wdata;
    return mregs[a];
  endfunction

  // Applies the edge rules to the model using the inputs held across the edge.
  task automatic model_edge();
    if (clearing) begin
      mregs[pos] = '0;
      mbusy[pos] = 1'b0;
      if (pos == 31) clearing = 0;
      else pos++;
    end else begin
      if (we) begin
        if (waddr != 0) mregs[waddr] = wdata;
        mbusy[waddr] = 1'b0;
      end
      if (rsv_valid && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
      if (clr_req) begin
        clearing = 1;
        pos = 1;
      end
    end
    mbusy[0] = 1'b0;
  endtask

  task automatic check_all();
    chk("rdata0", {32'h0, rdata[31:0]}, {32'h0, exp_read(raddr[4:0])});
    chk("rdata1", {32'h0, rdata[63:32]}, {32'h0, exp_read(raddr[9:5])});
    chk("busy", {32'h0, busy}, {32'h0, mbusy});
    chk("clr_busy", {63'h0, clr_busy}, {63'h0, clearing});
    chk("wr_ready", {63'h0, wr_ready}, {63'h0, !clearing});
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 0; rsv_valid = 0; clr_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk("rst_clr_busy", {63'h0, clr_busy}, 64'h0);
    chk("rst_wr_ready", {63'h0, wr_ready}, 64'h1);
    chk("rst_busy", {32'h0, busy}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    we = 1; waddr = a; wdata = d;
    cyc();
    we = 0;
  endtask

  task automatic sweep_expect(input logic [4:0] only, input logic [31:0] val, input string name);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      raddr[4:0] = 5'(i);
      raddr[9:5] = 5'(31 - i);
      #1;
      chk(name, {32'h0, rdata[31:0]}, {32'h0, (i == only && only != 0) ? val : 32'h0});
      cyc();
    end
  endtask

  task automatic fill_all();
    for (int i = 1; i < 32; i++) write(5'(i), 32'h0101_0101 * i | 32'h8000_0000);
  endtask

  int n;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single write read back on both ports; everything else zero.
    write(5'd5, 32'hDEAD_BEEF);
    raddr = {5'd5, 5'd5};
    #1;
    chk("r5_port0", {32'h0, rdata[31:0]}, 64'hDEAD_BEEF);
    chk("r5_port1", {32'h0, rdata[63:32]}, 64'hDEAD_BEEF);
    cyc();
    sweep_expect(5'd5, 32'hDEAD_BEEF, "after_r5");

    // Register 0 is immutable.
    write(5'd0, 32'h1234_5678);
    raddr = '0;
    #1;
    chk("r0_read", {32'h0, rdata[31:0]}, 64'h0);
    chk("busy0", {63'h0, busy[0]}, 64'h0);
    cyc();

    // Same-cycle forwarding.
    we = 1; waddr = 5'd31; wdata = 32'hA5A5_A5A5; raddr = {5'd1, 5'd31};
    #1;
    chk("bypass_r31", {32'h0, rdata[31:0]}, 64'hA5A5_A5A5);
    chk("r1_unchanged", {32'h0, rdata[63:32]}, 64'h0);
    cyc();
    we = 0;

    // Reserve r7, write it two cycles later.
    rsv_valid = 1; rsv_addr = 5'd7;
    cyc();
    rsv_valid = 0;
    n = 0;
    for (int j = 0; j < 4; j++) begin
      if (j == 1) begin we = 1; waddr = 5'd7; wdata = 32'h77; end
      #1;
      if (busy[7]) n++;
      cyc();
      we = 0;
    end
    chk("busy7_cycles", 64'(n), 64'd2);

    // Reservation and write on the same register: reservation wins.
    rsv_valid = 1; rsv_addr = 5'd7; we = 1; waddr = 5'd7; wdata = 32'h99;
    cyc();
    idle_inputs();
    #1 chk("busy7_rsv_wins", {63'h0, busy[7]}, 64'h1);

    // Full clear with a write attempted mid-clear.
    fill_all();
    clr_req = 1;
    cyc();
    clr_req = 0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) begin we = 1; waddr = 5'd9; wdata = 32'hBAD0_BAD0; end
      #1;
      if (clr_busy) begin
        n++;
        chk("wr_ready_in_clear", {63'h0, wr_ready}, 64'h0);
      end
      cyc();
      we = 0;
    end
    chk("clear_cycles", 64'(n), 64'd31);
    sweep_expect(5'd0, 32'h0, "after_clear");

    // Reset aborts a clear in progress.
    fill_all();
    clr_req = 1;
    cyc();
    clr_req = 0;
    for (int c = 0; c < 10; c++) cyc();
    #2;
    do_reset();
    sweep_expect(5'd0, 32'h0, "after_abort");

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        we        = ($urandom_range(0, 1) == 1);
        waddr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        wdata     = $urandom;
        rsv_valid = ($urandom_range(0, 2) == 0);
        rsv_addr  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
        clr_req   = ($urandom_range(0, 149) == 0);
        raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
        raddr[9:5] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
        cyc();
      end
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
